// File: rtl/board_debug_ctrl.sv
// Board-interface controller: switch debounce, processor clock-enable (step/run/halt),
// executed-cycle counter on LED and multiplexed hex display on the 7-segment outputs.
module board_debug_ctrl #(
    parameter int unsigned NBITS     = 8,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned RUN_DIV   = 4,
    parameter int unsigned SCAN_DIV  = 2,
    parameter int unsigned STEP_BIT  = 0,
    parameter int unsigned MODE_BIT  = 1,
    localparam int unsigned NDIG     = NBITS / 4,
    localparam int unsigned DSW      = $clog2(NDIG)
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] SWI,
    input  logic             halt,
    input  logic [NBITS-1:0] disp_val,
    output logic [NBITS-1:0] sw_db,
    output logic             cpu_en,
    output logic [NBITS-1:0] LED,
    output logic [DSW-1:0]   digit_sel,
    output logic [7:0]       SEG
);

    localparam int unsigned DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned DIVW = $clog2(RUN_DIV);
    localparam int unsigned SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(RUN_DIV - 1);
    localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [DSW-1:0]  DIG_LAST  = DSW'(NDIG - 1);

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    logic [NBITS-1:0] sw_db_q, sw_db_d;
    logic [DBW-1:0]   db_cnt_q [NBITS];
    logic [DBW-1:0]   db_cnt_d [NBITS];
    logic             step_prev_q, step_prev_d;
    logic             cpu_en_q, cpu_en_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic [NBITS-1:0] led_q, led_d;
    logic [SCW-1:0]   scan_q, scan_d;
    logic [DSW-1:0]   dig_q, dig_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       nib;
    mode_e            mode;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign mode = mode_e'(sw_db_q[MODE_BIT]);

    // Per-bit debounce: a bit is accepted after DB_CYCLES consecutive mismatching edges.
    always_comb begin
        sw_db_d = sw_db_q;
        for (int unsigned i = 0; i < NBITS; i++) begin
            db_cnt_d[i] = '0;
            if (SWI[i] != sw_db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    sw_db_d[i] = SWI[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // step_prev tracks the button in both modes so returning to step mode with the
    // button already held does not fire a pulse.
    always_comb begin
        step_prev_d = sw_db_q[STEP_BIT];
        cpu_en_d    = 1'b0;
        div_d       = '0;
        case (mode)
            MODE_RUN: begin
                cpu_en_d = (div_q == DIV_LAST) && !halt;
                if (halt) begin
                    div_d = div_q;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + DIVW'(1);
                end
            end
            default: begin
                cpu_en_d = sw_db_q[STEP_BIT] && !step_prev_q && !halt;
            end
        endcase
        led_d = cpu_en_q ? led_q + NBITS'(1) : led_q;
    end

    // SEG is computed from the digit index being loaded this edge so it always matches digit_sel.
    always_comb begin
        scan_d = scan_q + SCW'(1);
        dig_d  = dig_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + DSW'(1);
        end
        nib = '0;
        for (int unsigned d = 0; d < NDIG; d++) begin
            if (dig_d == DSW'(d)) begin
                nib = disp_val[4*d +: 4];
            end
        end
        seg_d = {dig_d == '0, hex7(nib)};
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            sw_db_q     <= '0;
            step_prev_q <= 1'b0;
            cpu_en_q    <= 1'b0;
            div_q       <= '0;
            led_q       <= '0;
            scan_q      <= '0;
            dig_q       <= '0;
            seg_q       <= '0;
            for (int unsigned i = 0; i < NBITS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sw_db_q     <= sw_db_d;
            step_prev_q <= step_prev_d;
            cpu_en_q    <= cpu_en_d;
            div_q       <= div_d;
            led_q       <= led_d;
            scan_q      <= scan_d;
            dig_q       <= dig_d;
            seg_q       <= seg_d;
            for (int unsigned i = 0; i < NBITS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign sw_db     = sw_db_q;
    assign cpu_en    = cpu_en_q;
    assign LED       = led_q;
    assign digit_sel = dig_q;
    assign SEG       = seg_q;

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Directed bench for board_debug_ctrl with hand-computed expectations (default parameters).
module tb_board_debug_ctrl;

    localparam int unsigned NBITS = 8;
    localparam int unsigned DSW   = 1;

    logic             clk_2 = 1'b0;
    logic             reset;
    logic [NBITS-1:0] SWI;
    logic             halt;
    logic [NBITS-1:0] disp_val;
    logic [NBITS-1:0] sw_db;
    logic             cpu_en;
    logic [NBITS-1:0] LED;
    logic [DSW-1:0]   digit_sel;
    logic [7:0]       SEG;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk_2 = ~clk_2;

    board_debug_ctrl #(
        .NBITS    (8),
        .DB_CYCLES(4),
        .RUN_DIV  (4),
        .SCAN_DIV (2),
        .STEP_BIT (0),
        .MODE_BIT (1)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .SWI      (SWI),
        .halt     (halt),
        .disp_val (disp_val),
        .sw_db    (sw_db),
        .cpu_en   (cpu_en),
        .LED      (LED),
        .digit_sel(digit_sel),
        .SEG      (SEG)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    initial begin
        int unsigned pulses;
        int unsigned pulse_at;
        int unsigned bad;
        int unsigned first_at;
        bit          found;

        reset    = 1'b1;
        SWI      = '0;
        halt     = 1'b0;
        disp_val = 8'hA5;
        tick(2);
        reset = 1'b0;
        check_eq("rst_sw_db", 32'(sw_db), 32'h0);
        check_eq("rst_cpu_en", 32'(cpu_en), 32'h0);
        check_eq("rst_led", 32'(LED), 32'h0);
        check_eq("rst_digit", 32'(digit_sel), 32'h0);
        check_eq("rst_seg", 32'(SEG), 32'h0);

        // display scan: 0xA5 -> digit0 ED, digit1 77
        tick(1); check_eq("scan1_dig", 32'(digit_sel), 32'd0); check_eq("scan1_seg", 32'(SEG), 32'hED);
        tick(1); check_eq("scan2_dig", 32'(digit_sel), 32'd1); check_eq("scan2_seg", 32'(SEG), 32'h77);
        tick(1); check_eq("scan3_dig", 32'(digit_sel), 32'd1); check_eq("scan3_seg", 32'(SEG), 32'h77);
        tick(1); check_eq("scan4_dig", 32'(digit_sel), 32'd0); check_eq("scan4_seg", 32'(SEG), 32'hED);
        disp_val = 8'h3C;
        tick(1); check_eq("scan5_seg", 32'(SEG), 32'hB9);
        tick(1); check_eq("scan6_seg", 32'(SEG), 32'h4F);

        // debounce: 3-cycle glitch rejected
        SWI = 8'h01;
        tick(3); check_eq("glitch_3", 32'(sw_db[0]), 32'd0);
        SWI = 8'h00;
        tick(1); check_eq("glitch_drop", 32'(sw_db[0]), 32'd0);
        tick(2);

        // step mode: press and hold 20 cycles -> single pulse one cycle after acceptance
        SWI = 8'h01; pulses = 0; pulse_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 3) check_eq("db_edge3", 32'(sw_db[0]), 32'd0);
            if (i == 4) check_eq("db_edge4", 32'(sw_db[0]), 32'd1);
            if (cpu_en) begin pulses++; pulse_at = i; end
        end
        check_eq("step_pulses", pulses, 32'd1);
        check_eq("step_pulse_at", pulse_at, 32'd5);
        check_eq("step_led", 32'(LED), 32'h01);
        SWI = 8'h00;
        tick(3); check_eq("db_hold_low3", 32'(sw_db[0]), 32'd1);
        tick(1); check_eq("db_release", 32'(sw_db[0]), 32'd0);

        // step edge during halt is lost, and not replayed on release
        halt = 1'b1; SWI = 8'h01; pulses = 0;
        for (int i = 0; i < 20; i++) begin tick(1); if (cpu_en) pulses++; end
        check_eq("halt_step_pulses", pulses, 32'd0);
        check_eq("halt_step_led", 32'(LED), 32'h01);
        halt = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(1); if (cpu_en) pulses++; end
        check_eq("halt_release_pulses", pulses, 32'd0);
        SWI = 8'h00;
        tick(4); check_eq("step_btn_off", 32'(sw_db), 32'h00);

        // run mode: pulse every 4th cycle after acceptance, LED wraps
        SWI = 8'h02;
        tick(3); check_eq("mode_pre", 32'(sw_db), 32'h00);
        tick(1); check_eq("mode_acc", 32'(sw_db), 32'h02);
        bad = 0; pulses = 0;
        for (int i = 1; i <= 1024; i++) begin
            tick(1);
            if (cpu_en !== ((i % 4) == 0)) bad++;
            if (cpu_en) pulses++;
        end
        check_eq("run_spacing_err", bad, 32'd0);
        check_eq("run_pulses", pulses, 32'd256);
        check_eq("run_led_wrap", 32'(LED), 32'h00);
        tick(1); check_eq("run_led_after", 32'(LED), 32'h01);

        // halt freezes divider (held at 1); resumes 3 cycles after release
        halt = 1'b1; pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (cpu_en) pulses++; end
        check_eq("halt_run_pulses", pulses, 32'd0);
        check_eq("halt_run_led", 32'(LED), 32'h01);
        halt = 1'b0;
        tick(1); check_eq("resume_1", 32'(cpu_en), 32'd0);
        tick(1); check_eq("resume_2", 32'(cpu_en), 32'd0);
        tick(1); check_eq("resume_3", 32'(cpu_en), 32'd1);
        tick(1); check_eq("resume_led", 32'(LED), 32'h02);

        // reset mid-run at LED=0x37, digit_sel=1
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick(1);
            if (LED == 8'h37 && digit_sel == 1'b1) found = 1'b1;
        end
        check_eq("reach_0x37", 32'(found), 32'd1);
        reset = 1'b1;
        tick(1);
        check_eq("mid_rst_sw_db", 32'(sw_db), 32'h0);
        check_eq("mid_rst_cpu_en", 32'(cpu_en), 32'h0);
        check_eq("mid_rst_led", 32'(LED), 32'h0);
        check_eq("mid_rst_digit", 32'(digit_sel), 32'h0);
        check_eq("mid_rst_seg", 32'(SEG), 32'h0);
        tick(1);
        reset = 1'b0;
        first_at = 0;
        for (int i = 1; i <= 20 && first_at == 0; i++) begin
            tick(1);
            if (i == 4) check_eq("redb_mode", 32'(sw_db), 32'h02);
            if (cpu_en) first_at = i;
        end
        check_eq("post_rst_first_pulse", first_at, 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
